neuron_mac_act: RTL and testbench

- Neuron front end that drives the sigmoid lookup ROM.
- Accepts a stream of (activation, weight) beats and adds a bias to the signed dot product.
- Quantises and clamps the accumulator into a 14-bit offset-binary ROM address, then issues the lookup.
- Captures the 1-cycle-latency ROM output and presents it on a valid/ready output port.

---
 rtl/neuron_pkg.sv | 29 ++
 rtl/neuron_addr_quant.sv | 43 ++++
 rtl/neuron_mac_act.sv | 160 ++++++++++++++++
 tb/tb_neuron_mac_act.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and constants for the neuron MAC/activation front end.
//   - neuron_state_e : sequencing states of neuron_mac_act
//   - ADDR_OFFSET    : offset-binary bias for the default 14-bit ROM address
//   - CLAMP_HI/LO    : signed clamp limits for the default ROM address width
//   - clamp_hi/lo()  : the same limits for an arbitrary address width
package neuron_pkg;

  localparam int NEURON_ADDR_WIDTH = 14;
  localparam int ADDR_OFFSET       = 1 << (NEURON_ADDR_WIDTH - 1);
  localparam int CLAMP_HI          = ADDR_OFFSET - 1;
  localparam int CLAMP_LO          = -ADDR_OFFSET;

  typedef enum logic [2:0] {
    ST_ACC  = 3'd0,
    ST_CONV = 3'd1,
    ST_ROMW = 3'd2,
    ST_CAPT = 3'd3,
    ST_OUT  = 3'd4
  } neuron_state_e;

  function automatic int clamp_hi(input int aw);
    return (1 << (aw - 1)) - 1;
  endfunction

  function automatic int clamp_lo(input int aw);
    return -(1 << (aw - 1));
  endfunction

endpackage

// File: rtl/neuron_addr_quant.sv
// neuron_addr_quant: combinational quantiser from accumulator to ROM address.
//   acc  in  ACC_WIDTH   signed accumulator
//   addr out ADDR_WIDTH  offset-binary ROM address
//   sat  out 1           the shifted value was clamped
// The accumulator is arithmetically shifted right by FRAC_SHIFT, clamped to
// the signed range of ADDR_WIDTH bits, then biased into offset binary.
module neuron_addr_quant
  import neuron_pkg::*;
#(
  parameter int ACC_WIDTH  = 24,
  parameter int ADDR_WIDTH = NEURON_ADDR_WIDTH,
  parameter int FRAC_SHIFT = 4
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic        [ADDR_WIDTH-1:0] addr,
  output logic                         sat
);

  localparam logic signed [ACC_WIDTH-1:0] LIM_HI = ACC_WIDTH'(clamp_hi(ADDR_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] LIM_LO = ACC_WIDTH'(clamp_lo(ADDR_WIDTH));
  // Offset equals LIM_HI + 1; adding it just inverts the address MSB.
  localparam logic signed [ACC_WIDTH-1:0] OFFSET = LIM_HI + ACC_WIDTH'(1);

  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [ACC_WIDTH-1:0] clamped;

  assign shifted = acc >>> FRAC_SHIFT;

  always_comb begin
    clamped = shifted;
    sat     = 1'b0;
    if (shifted > LIM_HI) begin
      clamped = LIM_HI;
      sat     = 1'b1;
    end else if (shifted < LIM_LO) begin
      clamped = LIM_LO;
      sat     = 1'b1;
    end
  end

  assign addr = ADDR_WIDTH'(clamped + OFFSET);

endmodule

// File: rtl/neuron_mac_act.sv
// neuron_mac_act: neuron front end feeding a 1-cycle-latency sigmoid ROM.
// Accumulates bias + sum(in_data*in_weight) over a beat stream, quantises the
// result to a ROM address, captures the ROM word and offers it downstream.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            input beat handshake
//   in_data, in_weight, in_last  signed activation, signed weight, final beat
//   bias                         signed bias, sampled on the first beat
//   rom_addr, rom_q              registered ROM address, ROM data (1 clk later)
//   out_valid/out_ready          result handshake
//   out_data, out_sat            activation result, clamp indicator
//
// Build option: define NEURON_ACC_SAT_EN to saturate the accumulator instead
// of wrapping; a saturation event then also forces out_sat for that neuron.
//
// state | meaning
// ACC   | accepting beats, accumulating
// CONV  | quantise acc and register rom_addr
// ROMW  | ROM samples rom_addr
// CAPT  | capture rom_q into the output register
// OUT   | result valid, waiting for out_ready
module neuron_mac_act
  import neuron_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int W_WIDTH    = 8,
  parameter int ACC_WIDTH  = 24,  // at least IN_WIDTH+W_WIDTH+4
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_SHIFT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [IN_WIDTH-1:0]   in_data,
  input  logic signed [W_WIDTH-1:0]    in_weight,
  input  logic                         in_last,
  input  logic signed [ACC_WIDTH-1:0]  bias,
  output logic        [ADDR_WIDTH-1:0] rom_addr,
  input  logic        [DATA_WIDTH-1:0] rom_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [DATA_WIDTH-1:0] out_data,
  output logic                         out_sat
);

  localparam int PW = IN_WIDTH + W_WIDTH;

  neuron_state_e state_q, state_d;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] addend;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [PW-1:0]        prod;
  logic                        first;
  logic                        sat_r;
  logic                        accept;
  logic                        acc_sat_seen;
  logic [ADDR_WIDTH-1:0]       q_addr;
  logic                        q_sat;

  // Gated by rst_n so the port reads 0 while reset is held.
  assign in_ready = rst_n && (state_q == ST_ACC);
  assign accept   = in_valid && in_ready;

  assign prod     = in_data * in_weight;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  assign addend   = first ? bias : acc;

`ifdef NEURON_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] sum_x;
  logic                      acc_ovf;
  logic                      ovf_sticky;

  assign sum_x   = {addend[ACC_WIDTH-1], addend} + {prod_ext[ACC_WIDTH-1], prod_ext};
  assign acc_ovf = sum_x[ACC_WIDTH] ^ sum_x[ACC_WIDTH-1];

  always_comb begin
    acc_next = sum_x[ACC_WIDTH-1:0];
    if (acc_ovf) acc_next = sum_x[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      ovf_sticky <= first ? acc_ovf : (ovf_sticky | acc_ovf);
    end
  end

  assign acc_sat_seen = ovf_sticky;
`else
  assign acc_next     = addend + prod_ext;
  assign acc_sat_seen = 1'b0;
`endif

  neuron_addr_quant #(
    .ACC_WIDTH (ACC_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_quant (
    .acc (acc),
    .addr(q_addr),
    .sat (q_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (accept && in_last) state_d = ST_CONV;
      ST_CONV: state_d = ST_ROMW;
      ST_ROMW: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_OUT;
      ST_OUT:  if (out_valid && out_ready) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      first     <= 1'b1;
      rom_addr  <= '0;
      sat_r     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (accept) begin
        acc   <= acc_next;
        // Last beat re-arms bias sampling for the next neuron.
        first <= in_last;
      end
      if (state_q == ST_CONV) begin
        rom_addr <= q_addr;
        sat_r    <= q_sat;
      end
      if (state_q == ST_CAPT) begin
        out_data  <= rom_q;
        out_sat   <= sat_r | acc_sat_seen;
        out_valid <= 1'b1;
      end
      if (state_q == ST_OUT && out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_act.sv
// Self-checking bench for neuron_mac_act with a registered sigmoid ROM model.
module tb_neuron_mac_act;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic signed [7:0] in_weight;
  logic              in_last;
  logic signed [23:0] bias;
  logic [13:0]       rom_addr;
  logic [7:0]        rom_q;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_sat;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int bd[8];
  int bw[8];
  int nb;

  neuron_mac_act dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_weight(in_weight),
    .in_last  (in_last),
    .bias     (bias),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [13:0] a);
    logic [13:0] t;
    t = a ^ (a >> 3);
    t = t * 14'd73;
    return t[7:0] ^ t[13:6];
  endfunction

  always @(posedge clk) rom_q <= rom_f(rom_addr);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rom_addr"},  64'(rom_addr),  64'd0);
    check({tag, "_out_data"},  64'(out_data),  64'd0);
    check({tag, "_out_sat"},   64'(out_sat),   64'd0);
  endtask

  // Starts and ends at posedge+1. bd/bw/nb hold the beats. With abort set,
  // reset is pulsed while the ROM read is in flight and no result may appear.
  task automatic run_neuron(input int b, input int hold, input bit abort);
    longint             a;
    logic signed [23:0] a24;
    longint             s;
    int                 exp_addr;
    logic               exp_sat;
    logic [7:0]         exp_data;

    a = b;
    for (int i = 0; i < nb; i++) a += longint'(bd[i]) * longint'(bw[i]);
    a24 = a[23:0];
    s = longint'(a24) >>> 4;
    exp_sat = 1'b0;
    if (s > 8191) begin s = 8191; exp_sat = 1'b1; end
    else if (s < -8192) begin s = -8192; exp_sat = 1'b1; end
    exp_addr = int'(s) + 8192;
    exp_data = rom_f(14'(exp_addr));

    check("ready_at_start", 64'(in_ready), 64'd1);
    for (int i = 0; i < nb; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'(bd[i]);
      in_weight = 8'(bw[i]);
      in_last   = (i == nb - 1);
      bias      = (i == 0) ? 24'(b) : 24'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("ready_low_conv", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("rom_addr_e1", 64'(rom_addr), 64'(exp_addr));
    if (abort) begin
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_romw");
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
        check("no_valid_after_abort", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
      end
      return;
    end
    @(posedge clk); #1;
    check("valid_low_e2", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("valid_e3", 64'(out_valid), 64'd1);
    check("out_data", 64'(out_data), 64'(exp_data));
    check("out_sat", 64'(out_sat), 64'(exp_sat));
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_last   = 1'b1;
      in_data   = 8'($urandom);
      in_weight = 8'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(out_data), 64'(exp_data));
      check("hold_sat", 64'(out_sat), 64'(exp_sat));
      check("hold_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_cleared", 64'(out_valid), 64'd0);
    check("ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b0;

    #12;
    check_reset_outputs("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-beat neuron, acc = 44 -> address 0x2002.
    nb = 3;
    bd[0] = 10; bw[0] = 5;
    bd[1] = -4; bw[1] = 7;
    bd[2] = 2;  bw[2] = 3;
    run_neuron(16, 0, 1'b0);

    // Single beats probing the clamp boundaries and the address midpoint.
    nb = 1; bd[0] = 0; bw[0] = 0;
    run_neuron(-1, 0, 1'b0);
    run_neuron(32'h0010_0000, 0, 1'b0);
    run_neuron(-32'h0010_0000, 5, 1'b0);
    run_neuron(131071, 0, 1'b0);
    run_neuron(131072, 0, 1'b0);
    run_neuron(-131072, 0, 1'b0);
    run_neuron(-131073, 0, 1'b0);

    // Two's-complement wrap past the accumulator maximum.
    nb = 1; bd[0] = 127; bw[0] = 127;
    run_neuron(32'h007F_FFFF, 1, 1'b0);

    // Reset mid-accumulation: partial sum and pending beats are discarded.
    in_valid = 1'b1; in_data = 8'sd100; in_weight = 8'sd100; in_last = 1'b0; bias = 24'sd5000;
    @(posedge clk); #1;
    in_data = -8'sd90; in_weight = 8'sd77; bias = 24'sd1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_acc");
    in_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    nb = 2; bd[0] = 3; bw[0] = -9; bd[1] = 50; bw[1] = 20;
    run_neuron(-200, 0, 1'b0);

    // Reset while the ROM read is in flight.
    nb = 2; bd[0] = 60; bw[0] = 60; bd[1] = -7; bw[1] = 12;
    run_neuron(4000, 0, 1'b1);
    run_neuron(4000, 2, 1'b0);

    // Randomised back-to-back neurons.
    for (int n = 0; n < 24; n++) begin
      int b;
      int mode;
      nb = $urandom_range(1, 8);
      for (int i = 0; i < nb; i++) begin
        bd[i] = $urandom_range(0, 255) - 128;
        bw[i] = $urandom_range(0, 255) - 128;
      end
      mode = $urandom_range(0, 2);
      if (mode == 0)      b = $urandom_range(0, 4000) - 2000;
      else if (mode == 1) b = $urandom_range(0, 400000) - 200000;
      else                b = $urandom_range(0, 32'hFF_FFFF) - 32'h80_0000;
      run_neuron(b, $urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
